// File: rtl/vga_sync_rx_if.sv
// Sync receiver bus: sync inputs from the video source and recovered timing outputs.
// Ports (signals):
//   hsync_in, vsync_in  : active-low sync from the source
//   pixel_x, pixel_y    : recovered column / row
//   video_on            : locked and inside the active area
//   locked              : timing lock
//   frame_start         : one-clock pulse at (0,0) while locked
//   sync_err            : one-clock pulse per detected timing error
//   line_len            : last measured clocks per line
//   frame_lines         : last measured lines per frame
interface vga_sync_rx_if;
    logic        hsync_in;
    logic        vsync_in;
    logic [11:0] pixel_x;
    logic [11:0] pixel_y;
    logic        video_on;
    logic        locked;
    logic        frame_start;
    logic        sync_err;
    logic [11:0] line_len;
    logic [11:0] frame_lines;

    // Source / observer side
    modport master (
        output hsync_in, vsync_in,
        input  pixel_x, pixel_y, video_on, locked, frame_start, sync_err,
               line_len, frame_lines
    );

    // Receiver side
    modport slave (
        input  hsync_in, vsync_in,
        output pixel_x, pixel_y, video_on, locked, frame_start, sync_err,
               line_len, frame_lines
    );
endinterface

// File: rtl/vga_sync_rx.sv
// VGA sync receiver: recovers pixel/line position from hsync/vsync, measures
// line and frame timing, flags timing errors and locks after clean frames.
// Ports:
//   clk  : pixel clock (same clock as the sync source)
//   rst  : synchronous active-high reset
//   bus  : vga_sync_rx_if.slave (sync inputs, position/status outputs)
module vga_sync_rx #(
    parameter int unsigned HD          = 640,
    parameter int unsigned HR          = 16,
    parameter int unsigned HRET        = 96,
    parameter int unsigned HL          = 48,
    parameter int unsigned VD          = 480,
    parameter int unsigned VB          = 1,
    parameter int unsigned VRET        = 2,
    parameter int unsigned VT          = 42,
    parameter int unsigned LOCK_FRAMES = 2,
    parameter int unsigned HTIMEOUT    = 1024
) (
    input  logic          clk,
    input  logic          rst,
    vga_sync_rx_if.slave  bus
);
    localparam int unsigned CW   = 12;
    localparam int unsigned HTOT = HD + HR + HRET + HL;
    localparam int unsigned VTOT = VD + VB + VRET + VT;
    localparam int unsigned VSW  = VRET * HTOT;
    localparam logic [CW-1:0] CMAX = '1;

    localparam logic [1:0] S_SEARCH = 2'd0;
    localparam logic [1:0] S_TRACK  = 2'd1;
    localparam logic [1:0] S_LOCKED = 2'd2;

    logic          r_hs_prev, r_vs_prev;
    logic [CW-1:0] r_x, r_y;
    logic [CW-1:0] r_lcnt, r_hwid, r_vwid, r_hcnt;
    logic [CW-1:0] r_line_len, r_frame_lines;
    logic          r_h_armed, r_v_armed;
    logic [1:0]    r_state;
    logic [CW-1:0] r_good;
    logic          r_video_on, r_locked, r_frame_start, r_sync_err;

    logic          w_hfall, w_hrise, w_vfall, w_vrise;
    logic          w_xwrap;
    logic [CW-1:0] w_x_next, w_y_next;
    logic          w_h_err, w_v_err, w_err;
    logic [1:0]    w_state_next;
    logic [CW-1:0] w_good_next;
    logic          w_lock_next;

    // Sync edge detection against the previous-clock sample
    assign w_hfall = !bus.hsync_in &&  r_hs_prev;
    assign w_hrise =  bus.hsync_in && !r_hs_prev;
    assign w_vfall = !bus.vsync_in &&  r_vs_prev;
    assign w_vrise =  bus.vsync_in && !r_vs_prev;

    // Position counters: sync falls re-align them to the start of the sync pulse
    assign w_xwrap = !w_hfall && (r_x == CW'(HTOT - 1));

    always_comb begin
        w_x_next = r_x + CW'(1);
        w_y_next = r_y;
        if (w_hfall)
            w_x_next = CW'(HD + HR);
        else if (w_xwrap)
            w_x_next = '0;
        if (w_vfall)
            w_y_next = CW'(VD + VB);
        else if (w_xwrap)
            w_y_next = (r_y == CW'(VTOT - 1)) ? '0 : r_y + CW'(1);
    end

    // Timing checks; armed flags suppress checks until a full interval has been seen
    assign w_h_err = r_h_armed && ((w_hfall && (r_lcnt != CW'(HTOT))) ||
                                   (w_hrise && (r_hwid != CW'(HRET))) ||
                                   (!w_hfall && (r_lcnt == CW'(HTIMEOUT))));
    assign w_v_err = r_v_armed && ((w_vfall && (r_hcnt != CW'(VTOT))) ||
                                   (w_vrise && (r_vwid != CW'(VSW))));
    assign w_err   = w_h_err || w_v_err;

    // Lock state machine
    always_comb begin
        w_state_next = r_state;
        w_good_next  = r_good;
        case (r_state)
            S_SEARCH: begin
                if (w_vfall && !w_err) begin
                    w_state_next = S_TRACK;
                    w_good_next  = '0;
                end
            end
            S_TRACK: begin
                if (w_err) begin
                    w_state_next = S_SEARCH;
                end else if (w_vfall) begin
                    w_good_next = r_good + CW'(1);
                    if (w_good_next >= CW'(LOCK_FRAMES))
                        w_state_next = S_LOCKED;
                end
            end
            S_LOCKED: begin
                if (w_err)
                    w_state_next = S_SEARCH;
            end
            default: w_state_next = S_SEARCH;
        endcase
    end

    assign w_lock_next = (w_state_next == S_LOCKED);

    // State, counters and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hs_prev     <= 1'b1;
            r_vs_prev     <= 1'b1;
            r_x           <= '0;
            r_y           <= '0;
            r_lcnt        <= '0;
            r_hwid        <= '0;
            r_vwid        <= '0;
            r_hcnt        <= '0;
            r_line_len    <= '0;
            r_frame_lines <= '0;
            r_h_armed     <= 1'b0;
            r_v_armed     <= 1'b0;
            r_state       <= S_SEARCH;
            r_good        <= '0;
            r_video_on    <= 1'b0;
            r_locked      <= 1'b0;
            r_frame_start <= 1'b0;
            r_sync_err    <= 1'b0;
        end else begin
            r_hs_prev <= bus.hsync_in;
            r_vs_prev <= bus.vsync_in;
            r_x       <= w_x_next;
            r_y       <= w_y_next;

            // Clocks per line, saturating
            if (w_hfall) begin
                r_lcnt     <= CW'(1);
                r_line_len <= r_lcnt;
            end else if (r_lcnt != CMAX) begin
                r_lcnt <= r_lcnt + CW'(1);
            end

            // hsync / vsync low widths in clocks, saturating
            if (w_hfall)
                r_hwid <= CW'(1);
            else if (!bus.hsync_in && (r_hwid != CMAX))
                r_hwid <= r_hwid + CW'(1);

            if (w_vfall)
                r_vwid <= CW'(1);
            else if (!bus.vsync_in && (r_vwid != CMAX))
                r_vwid <= r_vwid + CW'(1);

            // Lines per frame (hsync falls between vsync falls)
            if (w_vfall) begin
                r_hcnt        <= w_hfall ? CW'(1) : '0;
                r_frame_lines <= r_hcnt;
            end else if (w_hfall && (r_hcnt != CMAX)) begin
                r_hcnt <= r_hcnt + CW'(1);
            end

            // Any error restarts measurement from a fresh edge
            if (w_err) begin
                r_h_armed <= 1'b0;
                r_v_armed <= 1'b0;
            end else begin
                if (w_hfall) r_h_armed <= 1'b1;
                if (w_vfall) r_v_armed <= 1'b1;
            end

            r_state       <= w_state_next;
            r_good        <= w_good_next;
            r_locked      <= w_lock_next;
            r_video_on    <= w_lock_next && (w_x_next < CW'(HD)) && (w_y_next < CW'(VD));
            r_frame_start <= w_lock_next && (w_x_next == '0) && (w_y_next == '0);
            r_sync_err    <= w_err;
        end
    end

    assign bus.pixel_x     = r_x;
    assign bus.pixel_y     = r_y;
    assign bus.video_on    = r_video_on;
    assign bus.locked      = r_locked;
    assign bus.frame_start = r_frame_start;
    assign bus.sync_err    = r_sync_err;
    assign bus.line_len    = r_line_len;
    assign bus.frame_lines = r_frame_lines;
endmodule
